// File: rtl/spi_master_byte.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte master.
// One byte out on MOSI and one byte in from MISO per transaction, MSB first,
// framed by its own active-low chip select. All outputs are registered.
module spi_master_byte #(
  parameter int CLK_DIV  = 4,  // clk cycles per SCK half-period, >= 2
  parameter int CS_SETUP = 2,  // CS low cycles before the first SCK low phase, >= 1
  parameter int CS_HOLD  = 2   // CS low cycles after the last SCK fall, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SPI_SCK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CS
);

  localparam int HW   = $clog2(CLK_DIV);
  localparam int GMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

  localparam logic [HW-1:0] HALF_LAST  = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] SETUP_LAST = GW'(CS_SETUP - 1);
  localparam logic [GW-1:0] HOLD_LAST  = GW'(CS_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;      // half-period counter, reloads each SCK edge
  logic [GW-1:0] gcnt_q, gcnt_d;      // CS setup/hold guard counter
  logic [2:0]    bit_q, bit_d;        // bit index within the frame
  logic [7:0]    tx_sr_q, tx_sr_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          sck_q, sck_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          rx_valid_q, rx_valid_d;
  logic          busy_q, busy_d;
  logic          tx_ready_q, tx_ready_d;

  // State and output registers; async reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hcnt_q     <= '0;
      gcnt_q     <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      gcnt_q     <= gcnt_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // Next-state and next-output logic for the IDLE/SETUP/XFER/HOLD sequencer.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    gcnt_d     = gcnt_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    tx_ready_d = tx_ready_q;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          // MSB goes out with CS so it is settled well before the first rise.
          tx_sr_d    = tx_data;
          mosi_d     = tx_data[7];
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
          gcnt_d     = '0;
          hcnt_d     = '0;
          bit_d      = '0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (gcnt_q == SETUP_LAST) begin
          gcnt_d  = '0;
          hcnt_d  = '0;
          state_d = XFER;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      XFER: begin
        if (hcnt_q == HALF_LAST) begin
          hcnt_d = '0;
          if (!sck_q) begin
            // Edge driving SCK high: capture MISO at the same instant.
            sck_d   = 1'b1;
            rx_sr_d = {rx_sr_q[6:0], SPI_MISO};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              // MOSI keeps bit 0 through the hold window.
              bit_d   = '0;
              gcnt_d  = '0;
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + 3'd1;
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
              mosi_d  = tx_sr_q[6];
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (gcnt_q == HOLD_LAST) begin
          gcnt_d     = '0;
          cs_d       = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
          state_d    = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS   = cs_q;

endmodule
